pkt_fifo_sc: RTL
================

// Module: pkt_fifo_sc
// PURPOSE
//  Single-clock packet FIFO: next generation of the sof/eof-tagged byte FIFO.
//  Width and depth are fully parametrised. Data and sof/eof are stored as one entry.
//  The read side only ever sees complete, committed packets.
//  Aborted, malformed or overflowing packets are rewound and discarded.
//  Sits between the MAC-side frame writer and the UDP header parser.
// PARAMETERS
//  DATA_WIDTH   8     payload bits per entry
//  DEPTH        1024  entries; power of 2, >=4; ADDR_W=$clog2(DEPTH)
//  ALMOST_FULL  960   almost_full asserts when occupancy (incl. uncommitted) >= this value
//  CNT_W        ADDR_W+1  width of pkt_count
// PORTS
//  clk          in   1           single clock, rising edge
//  reset        in   1           synchronous, active-high
//  wr_en        in   1           write strobe
//  wr_sof       in   1           first word of packet
//  wr_eof       in   1           last word of packet
//  wr_abort     in   1           with wr_en: discard packet in progress (word not stored)
//  din          in   DATA_WIDTH  write data
//  full         out  1           wr_ptr-rd_ptr==DEPTH
//  almost_full  out  1           see ALMOST_FULL
//  drop         out  1           1-cycle pulse per discarded packet/stray word
//  rd_en        in   1           read request
//  dout         out  DATA_WIDTH  read data, registered
//  rd_sof       out  1           sof of dout
//  rd_eof       out  1           eof of dout
//  rd_valid     out  1           dout/rd_sof/rd_eof valid this cycle
//  empty        out  1           rd_ptr==commit_ptr (no committed words)
//  pkt_count    out  CNT_W       committed packets not yet fully read
// BEHAVIOUR
//  Pointers wr_ptr, commit_ptr, rd_ptr: ADDR_W+1 bits, natural wrap; mem index = ptr[ADDR_W-1:0].
//  Reset: all ptrs 0, state IDLE, full/almost_full/drop/rd_valid 0, dout/rd_sof/rd_eof 0, empty 1, pkt_count 0.
//  Write FSM (IDLE, IN_PKT, DROP); word "stored" = mem[wr_ptr]<={eof,sof,din}, wr_ptr++.
//   IDLE: wr_en&sof&!abort&!full -> store, ->IN_PKT; if also eof, commit and stay IDLE.
//         wr_en without sof -> ignore, drop pulse. wr_en&sof&full -> drop pulse, ->DROP (IDLE if eof).
//   IN_PKT: wr_en&abort -> wr_ptr<=commit_ptr, drop, ->IDLE.
//           wr_en&sof -> wr_ptr<=commit_ptr, drop; restart: store new word at commit_ptr, stay IN_PKT.
//           wr_en&full -> wr_ptr<=commit_ptr, drop, ->DROP (->IDLE if eof).
//           wr_en&eof -> store; commit_ptr<=wr_ptr+1; pkt_count++; ->IDLE.
//   DROP: ignore words; wr_en&eof -> IDLE; wr_en&sof&!full -> treat as IDLE sof.
//  Precedence in one cycle: reset > abort > full > sof > eof.
//  Packets longer than DEPTH can never commit: always dropped.
//  full, almost_full and empty are combinational from the pointers.
//  Freed space (rd_ptr advance) is visible to full the next cycle.
//  Read: rd_en&!empty -> dout regs <= mem[rd_ptr], rd_ptr++, rd_valid=1 next cycle (latency 1).
//   rd_en&empty: ignored, rd_valid=0. dout holds last value when !rd_valid.
//   pkt_count-- on the cycle an eof word is read. Same-cycle commit and eof read: unchanged.
//   Reading the current write slot is impossible: reads stop at commit_ptr.
//  Reset mid-packet: all state cleared, partial packet lost; no drop pulse.
// STRUCTURE
//  pkt_fifo_pkg: wr_state_e {IDLE,IN_PKT,DROP}; function entry_w(DATA_WIDTH)=DATA_WIDTH+2.
//  Sub-module sdp_ram_sc: 1 write port, 1 registered read port, one clk, no reset on array.
//  Top level holds pointers, write FSM, pkt_count and flags.
// TESTING
//  1) 3-byte pkt (A1 sof, A2, A3 eof), then 3 rd_en -> dout A1/A2/A3, sof/eof on 1st/3rd, pkt_count 1->0.
//  2) Write 4 words then wr_abort -> empty stays 1, drop pulses once, wr_ptr==commit_ptr==0.
//  3) DEPTH=16: 20-word pkt -> full at word 16, drop once, DROP until eof.
//     Next 2-word pkt commits and reads back correctly.
//  4) sof mid-packet after 2 words: new 3-word pkt committed only. Stray word in IDLE -> drop, no store.
//  5) DEPTH=16: stream 40 1-word pkts while reading every cycle -> pointers wrap.
//     Data in order, pkt_count never <0, same-cycle commit/eof read holds count.
//  6) Reset asserted mid-packet and mid-read -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the single-clock packet FIFO.
package pkt_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } wr_state_e;

    // Stored entry is {eof, sof, data}.
    function automatic int entry_w(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/sdp_ram_sc.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Only the read register is reset; the array itself carries no reset.
module sdp_ram_sc #(
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] rdata_q;

    // Array write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds its value when no read is issued
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_fifo_sc.sv
// Single-clock packet FIFO: the reader only sees committed packets; aborted,
// malformed or overflowing packets are rewound to commit_ptr and discarded.
module pkt_fifo_sc
    import pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 1024,
    parameter int ALMOST_FULL = 960,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sof,
    input  logic                  wr_eof,
    input  logic                  wr_abort,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    output logic                  drop,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_sof,
    output logic                  rd_eof,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [CNT_W-1:0]      pkt_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int EW     = entry_w(DATA_WIDTH);

    wr_state_e         state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  occupancy_s;
    logic [CNT_W-1:0]  pkt_count_q;
    logic              drop_q, drop_d;
    logic              rd_valid_q;
    logic              commit_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic              full_s, empty_s, rd_fire_s, rd_eof_s;
    logic [EW-1:0]     rdata_s;

    // eof side copy lets pkt_count drop on the same edge the eof word is read
    logic              eof_flag_q [0:DEPTH-1];

    assign occupancy_s = wr_ptr_q - rd_ptr_q;
    assign full_s      = (occupancy_s == PTR_W'(DEPTH));
    assign empty_s     = (rd_ptr_q == commit_ptr_q);
    assign rd_fire_s   = rd_en & ~empty_s;
    assign rd_eof_s    = eof_flag_q[rd_ptr_q[ADDR_W-1:0]];

    // Write FSM next-state: store, commit, rewind and drop decisions
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_d       = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = wr_ptr_q[ADDR_W-1:0];
        commit_s     = 1'b0;
        if (wr_en) begin
            case (state_q)
                IN_PKT: begin
                    if (wr_abort) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_d   = 1'b1;
                        state_d  = IDLE;
                    end else if (full_s) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_d   = 1'b1;
                        state_d  = wr_eof ? IDLE : DROP;
                    end else if (wr_sof) begin
                        // Restart: the new packet overwrites the partial one
                        drop_d      = 1'b1;
                        mem_we_s    = 1'b1;
                        mem_waddr_s = commit_ptr_q[ADDR_W-1:0];
                        wr_ptr_d    = commit_ptr_q + PTR_W'(1);
                        if (wr_eof) begin
                            commit_ptr_d = commit_ptr_q + PTR_W'(1);
                            commit_s     = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            state_d = IN_PKT;
                        end
                    end else begin
                        mem_we_s = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        if (wr_eof) begin
                            commit_ptr_d = wr_ptr_q + PTR_W'(1);
                            commit_s     = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            state_d = IN_PKT;
                        end
                    end
                end
                IDLE, DROP: begin
                    if (wr_abort) begin
                        drop_d  = (state_q == IDLE);
                        state_d = IDLE;
                    end else if (wr_sof) begin
                        if (full_s) begin
                            drop_d  = 1'b1;
                            state_d = wr_eof ? IDLE : DROP;
                        end else begin
                            mem_we_s = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            if (wr_eof) begin
                                commit_ptr_d = wr_ptr_q + PTR_W'(1);
                                commit_s     = 1'b1;
                                state_d      = IDLE;
                            end else begin
                                state_d = IN_PKT;
                            end
                        end
                    end else if (state_q == IDLE) begin
                        drop_d = 1'b1;
                    end else if (wr_eof) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pointer, FSM, flag and packet-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            drop_q       <= drop_d;
            rd_valid_q   <= rd_fire_s;
            if (rd_fire_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({commit_s, rd_fire_s & rd_eof_s})
                2'b10:   pkt_count_q <= pkt_count_q + CNT_W'(1);
                2'b01:   pkt_count_q <= pkt_count_q - CNT_W'(1);
                default: pkt_count_q <= pkt_count_q;
            endcase
        end
    end

    // eof flag side array, written alongside the RAM
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            eof_flag_q[mem_waddr_s] <= wr_eof;
        end
    end

    sdp_ram_sc #(
        .WIDTH  (EW),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (reset),
        .we_i    (mem_we_s),
        .waddr_i (mem_waddr_s),
        .wdata_i ({wr_eof, wr_sof, din}),
        .re_i    (rd_fire_s),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata_s)
    );

    assign {rd_eof, rd_sof, dout} = rdata_s;
    assign full        = full_s;
    assign almost_full = (occupancy_s >= PTR_W'(ALMOST_FULL));
    assign empty       = empty_s;
    assign drop        = drop_q;
    assign rd_valid    = rd_valid_q;
    assign pkt_count   = pkt_count_q;

endmodule
